fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with a stall buffer and branch redirect.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, buf_q, buf_d;
  logic valid_q, valid_d;
  logic [31:0] pc_inc;
  assign pc_inc = pc_q + 32'd4;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    buf_d   = buf_q;
    if (branch_taken) begin
      // redirect squashes IF/ID and any word parked during a stall
      pc_d    = branch_target & 32'hFFFF_FFFC;
      instr_d = '0;
      valid_d = 1'b0;
      buf_d   = '0;
      state_d = FETCH;
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (!stall && imem_ready) begin
            instr_d = imem_rdata;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end else if (!stall) begin
            instr_d = '0;
            valid_d = 1'b0;
          end else if (imem_ready) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d = buf_q;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q[7:0];
  assign pc_out     = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios for fetch_stage against hand-computed IF/ID and PC values.
module tb_fetch_stage;
  logic        clk, reset, stall, branch_taken, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, ifid_valid;
  logic [7:0]  imem_addr;
  logic [31:0] pc_out, ifid_instr, ifid_pc4;
  logic [31:0] rom [64];
  logic [105:0] obs, exp;
  int checks, errors;
  localparam logic [31:0] W0 = 32'hA000C000, W1 = 32'hA001C001, W2 = 32'hA002C002, W3 = 32'hA003C003;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc_out(pc_out),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  assign imem_rdata = rom[imem_addr[7:2]];
  assign obs = {imem_req, imem_addr, pc_out, ifid_instr, ifid_pc4, ifid_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b1;
    #2;
    exp = {1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset_initial: got %h expected %h", obs, exp); end
    @(negedge clk);
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset_held_over_edge: got %h expected %h", obs, exp); end
  endtask

  task automatic test_stream();
    logic [31:0] w [4];
    w[0] = W0; w[1] = W1; w[2] = W2; w[3] = W3;
    do_reset();
    @(negedge clk);
    exp = {1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL stream_first_req: got %h expected %h", obs, exp); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp = {1'b1, 8'(4 * (k + 1)), 32'(4 * (k + 1)), w[k], 32'(4 * (k + 1)), 1'b1};
      checks++; if (obs !== exp) begin errors++; $display("FAIL stream_w%0d: got %h expected %h", k, obs, exp); end
    end
  endtask

  task automatic test_wait();
    do_reset();
    repeat (3) @(negedge clk);
    exp = {1'b1, 8'h08, 32'h8, W1, 32'h8, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL wait_pre: got %h expected %h", obs, exp); end
    imem_ready = 1'b0;
    exp = {1'b1, 8'h08, 32'h8, 32'h0, 32'h8, 1'b0};
    @(negedge clk);
    checks++; if (obs !== exp) begin errors++; $display("FAIL wait_bubble1: got %h expected %h", obs, exp); end
    @(negedge clk);
    checks++; if (obs !== exp) begin errors++; $display("FAIL wait_bubble2: got %h expected %h", obs, exp); end
    imem_ready = 1'b1;
    @(negedge clk);
    exp = {1'b1, 8'h0C, 32'hC, W2, 32'hC, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL wait_resume: got %h expected %h", obs, exp); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (2) @(negedge clk);
    exp = {1'b1, 8'h04, 32'h4, W0, 32'h4, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL stall_pre: got %h expected %h", obs, exp); end
    stall = 1'b1;
    exp = {1'b0, 8'h04, 32'h4, W0, 32'h4, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (obs !== exp) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", k, obs, exp); end
    end
    stall = 1'b0;
    @(negedge clk);
    exp = {1'b1, 8'h08, 32'h8, W1, 32'h8, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL stall_release: got %h expected %h", obs, exp); end
    @(negedge clk);
    exp = {1'b1, 8'h0C, 32'hC, W2, 32'hC, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL stall_resume: got %h expected %h", obs, exp); end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (2) @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    exp = {1'b0, 8'h04, 32'h4, W0, 32'h4, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL branch_in_hold: got %h expected %h", obs, exp); end
    branch_taken = 1'b1; branch_target = 32'h23;
    @(negedge clk);
    exp = {1'b1, 8'h20, 32'h20, 32'h0, 32'h4, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL branch_redirect: got %h expected %h", obs, exp); end
    branch_taken = 1'b0; stall = 1'b0;
    @(negedge clk);
    exp = {1'b1, 8'h24, 32'h24, 32'hA008C008, 32'h24, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL branch_target_word: got %h expected %h", obs, exp); end
  endtask

  task automatic test_async_reset();
    do_reset();
    branch_taken = 1'b1; branch_target = 32'h3C;
    @(negedge clk);
    exp = {1'b1, 8'h3C, 32'h3C, 32'h0, 32'h0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL areset_idle_branch: got %h expected %h", obs, exp); end
    branch_taken = 1'b0;
    @(negedge clk);
    exp = {1'b1, 8'h40, 32'h40, 32'hA00FC00F, 32'h40, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL areset_pre: got %h expected %h", obs, exp); end
    #1 reset = 1'b0;
    #2;
    exp = {1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL areset_immediate: got %h expected %h", obs, exp); end
    #1 reset = 1'b1;
    @(negedge clk);
    exp = {1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL areset_restart_req: got %h expected %h", obs, exp); end
    @(negedge clk);
    exp = {1'b1, 8'h04, 32'h4, W0, 32'h4, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL areset_restart_w0: got %h expected %h", obs, exp); end
  endtask

  task automatic test_wrap();
    do_reset();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    @(negedge clk);
    exp = {1'b1, 8'hFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL wrap_top: got %h expected %h", obs, exp); end
    branch_taken = 1'b0;
    @(negedge clk);
    exp = {1'b1, 8'h00, 32'h0, 32'hA03FC03F, 32'h0, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL wrap_zero: got %h expected %h", obs, exp); end
    @(negedge clk);
    exp = {1'b1, 8'h04, 32'h4, W0, 32'h4, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL wrap_w0: got %h expected %h", obs, exp); end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int k = 0; k < 64; k++) rom[k] = {8'hA0, 8'(k), 8'hC0, 8'(k)};
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_branch();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
